// File: rtl/dpram_share_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM sharing arbiter.
package dpram_share_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int AWIDTH_DEF  = 11;
  localparam int DWIDTH_DEF  = 60;

  // Requester ids are carried in 3 bits so up to 8 requesters fit.
  localparam int ID_W = 3;

  // Which RAM port a granted access was placed on.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Read tag travelling alongside the RAM's registered read.
  typedef struct packed {
    logic            valid;
    port_sel_e       port;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/dpram_share_arbiter_rr_pick2.sv
// Combinational round-robin picker returning the first two requesters at or after ptr.
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_a,
  output logic [N-1:0]  grant_b
);

  logic found_a;
  logic found_b;

  // Walk the requesters in rotated order; first hit goes to A, second to B.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        if (!found_a) begin
          grant_a[idx] = 1'b1;
          found_a      = 1'b1;
        end else if (!found_b) begin
          grant_b[idx] = 1'b1;
          found_b      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dpram_share_arbiter.sv
// Shares one external dual-port RAM between NUM_REQ requesters, two accesses per cycle.
module dpram_share_arbiter
  import dpram_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DWIDTH-1:0] rsp_data,
  output logic [AWIDTH-1:0]         address_a,
  output logic [AWIDTH-1:0]         address_b,
  output logic                      wren_a,
  output logic                      wren_b,
  output logic [DWIDTH-1:0]         data_a,
  output logic [DWIDTH-1:0]         data_b,
  input  logic [DWIDTH-1:0]         out_a,
  input  logic [DWIDTH-1:0]         out_b
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]        cand_a, cand_b;
  logic [NUM_REQ-1:0]        grant_a, grant_b;
  logic [AWIDTH-1:0]         addr_a, addr_b;
  logic [DWIDTH-1:0]         wdata_a, wdata_b;
  logic                      wr_a, wr_b;
  logic [ID_W-1:0]           id_a, id_b;
  logic                      collision;
  rd_tag_t                   tag_q[2];
  rd_tag_t                   tag_d[2];
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DWIDTH-1:0] rsp_data_q, rsp_data_d;

  rr_pick2 #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .grant_a (cand_a),
    .grant_b (cand_b)
  );

  // Pull out the command fields of the two candidates.
  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    id_a    = '0;
    id_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_a[i]) begin
        addr_a  = req_addr[i*AWIDTH +: AWIDTH];
        wdata_a = req_wdata[i*DWIDTH +: DWIDTH];
        wr_a    = req_wr[i];
        id_a    = ID_W'(i);
      end
      if (cand_b[i]) begin
        addr_b  = req_addr[i*AWIDTH +: AWIDTH];
        wdata_b = req_wdata[i*DWIDTH +: DWIDTH];
        wr_b    = req_wr[i];
        id_b    = ID_W'(i);
      end
    end
  end

  // Grant both candidates unless they touch the same word with a write, or reset is active.
  always_comb begin
    collision = (|cand_a) && (|cand_b) && (addr_a == addr_b) && (wr_a || wr_b);
    grant_a   = resetn ? cand_a : '0;
    grant_b   = (resetn && !collision) ? cand_b : '0;
    req_ready = grant_a | grant_b;
    address_a = (|grant_a) ? addr_a : '0;
    wren_a    = (|grant_a) && wr_a;
    data_a    = ((|grant_a) && wr_a) ? wdata_a : '0;
    address_b = (|grant_b) ? addr_b : '0;
    wren_b    = (|grant_b) && wr_b;
    data_b    = ((|grant_b) && wr_b) ? wdata_b : '0;
  end

  // Pointer moves just past the last requester served this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_a[i]) rr_ptr_d = PW'((i + 1) % NUM_REQ);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_b[i]) rr_ptr_d = PW'((i + 1) % NUM_REQ);
    end
  end

  // Tag each granted read so its data can be routed when the RAM returns it.
  always_comb begin
    tag_d[0] = '{valid: (|grant_a) && !wr_a, port: PORT_A, id: id_a};
    tag_d[1] = '{valid: (|grant_b) && !wr_b, port: PORT_B, id: id_b};
  end

  // Capture RAM output into the owning requester's slice; other slices keep their data.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_q[t].valid && (tag_q[t].id == ID_W'(i))) begin
          rsp_valid_d[i] = 1'b1;
          rsp_data_d[i*DWIDTH +: DWIDTH] = (tag_q[t].port == PORT_A) ? out_a : out_b;
        end
      end
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q    <= '0;
      tag_q[0]    <= '{valid: 1'b0, port: PORT_A, id: '0};
      tag_q[1]    <= '{valid: 1'b0, port: PORT_B, id: '0};
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_q[0]    <= tag_d[0];
      tag_q[1]    <= tag_d[1];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
